ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. It consumes the decoded bundle the ID stage produces: aluop, alusel, reg1, reg2, wd, wreg.
- Contains the ID/EX pipeline latch, the logic/shift/move ALU, the HI/LO special registers and the EX/MEM pipeline latch.
- Its ex_* outputs (combinational from the ID/EX latch) and mem_* outputs (registered) are the forwarding sources ID reads back.

Parameters:
- DATA_W, 32, datapath and HI/LO width
- REGADDR_W, 5, GPR address width
- ALUOP_W, 8, aluop width
- ALUSEL_W, 3, alusel width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (rst==0 resets immediately)
- stall_i  in  1  1 = freeze both latches and suppress HI/LO writes
- aluop_i  in  ALUOP_W  operation from ID
- alusel_i  in  ALUSEL_W  result class from ID
- reg1_i  in  DATA_W  operand 1, or immediate/shift amount
- reg2_i  in  DATA_W  operand 2, or immediate
- wd_i  in  REGADDR_W  destination GPR
- wreg_i  in  1  GPR write enable
- ex_wreg_o  out  1  EX-stage write enable, forwarded to ID
- ex_wd_o  out  REGADDR_W  EX-stage destination, forwarded to ID
- ex_wdata_o  out  DATA_W  EX-stage result, forwarded to ID
- mem_wreg_o  out  1  registered write enable toward MEM, also forwarded to ID
- mem_wd_o  out  REGADDR_W  registered destination
- mem_wdata_o  out  DATA_W  registered result
- hi_o  out  DATA_W  current HI
- lo_o  out  DATA_W  current LO

Behaviour:
- Reset (rst low, asynchronous): both latches cleared; aluop=NOP, alusel=NOP, operands 0, wd 0, wreg 0; HI=LO=0. Every output reads 0 while rst is low, including during an operation in flight.
- Latency:
  - Bundle presented by ID in cycle N is captured at the end of N.
  - ex_* outputs valid in cycle N+1, combinational from the latch.
  - ex_* captured into EX/MEM at the end of N+1; mem_* valid in N+2.
- stall_i=1:
  - Neither latch loads; outputs hold.
  - No HI/LO write occurs; a write held by the stall is performed exactly once, on the first non-stalled edge.
- ALU (ex_wdata_o), selected by latched alusel:
  - LOGIC (001): OR_OP reg1|reg2; AND_OP reg1&reg2; XOR_OP reg1^reg2; NOR_OP ~(reg1|reg2).
  - SHIFT (010), amount = reg1[4:0], value = reg2: SLL_OP logical left; SRL_OP logical right; SRA_OP and SRAV_OP arithmetic right (sign-filled). Amount 0 passes reg2 unchanged.
  - MOVE (011): MFHI_OP returns HI; MFLO_OP returns LO; MOVN_OP and MOVZ_OP return reg1. The write decision for MOVN/MOVZ is already made by ID in wreg.
  - NOP (000) or any unlisted aluop/alusel pair: result 0.
- ex_wreg_o and ex_wd_o pass latched wreg and wd through unchanged; this stage never alters write enable.
- HI/LO:
  - MTHI_OP writes HI←reg1, and MTLO_OP writes LO←reg1, at the edge ending the EX cycle (same edge that loads EX/MEM).
  - A following MFHI/MFLO in the next cycle sees the new value; no extra forwarding is needed.
  - MTHI/MTLO arrive from ID with wreg=0 and produce ex_wdata 0.
- Simultaneous MTHI in EX with stall_i=1: HI holds; the write happens when stall_i falls.
- Register $0 receives no special handling here; write suppression for $0 belongs to the register file.

Decomposition:
- All aluop/alusel encodings and width constants live in the shared macro package: EXE_*_OP, EXE_RES_*, ZEROWORD, WRITEENABLE/WRITEDISABLE.
- Add RSTENABLE_N=1'b0 there for the active-low reset.
- One combinational sub-module, ex_alu: inputs aluop, alusel, reg1, reg2, hi, lo; output result.
- Latches and HI/LO stay in ex_stage.

Test Plan:
- Reset mid-operation: OR in flight, drop rst asynchronously between edges → all outputs 0 immediately; HI=LO=0 after release.
- OR: aluop=EXE_OR_OP, alusel=001, reg1=0x0000F0F0, reg2=0x00000F0F, wd=3, wreg=1 → N+1: ex_wdata=0x0000FFFF, ex_wd=3, ex_wreg=1; N+2: mem_* identical.
- Shifts: reg1=4, reg2=0x80000000 → SRA gives 0xF8000000, SRL gives 0x08000000, SLL gives 0x00000000. reg1=0, reg2=0x12345678 → all three give 0x12345678.
- MTHI reg1=0x12345678 followed back-to-back by MFHI wd=5 wreg=1 → MTHI cycle ex_wreg=0 and ex_wdata=0; MFHI cycle ex_wdata=0x12345678, ex_wd=5.
- Stall: MTLO reg1=0xA5A5A5A5 in EX, stall_i=1 for 2 cycles while ID changes inputs → ex/mem outputs frozen, lo_o unchanged; LO=0xA5A5A5A5 after first unstalled edge; MTLO result enters EX/MEM only once.
- Default: alusel=000, aluop=0xFF, wreg=1, wd=7 → ex_wdata=0, ex_wreg=1, ex_wd=7.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared aluop/alusel encodings and constants for the execute stage
package ex_stage_pkg;
   localparam logic [31:0] ZEROWORD     = 32'h0000_0000;
   localparam logic        WRITEENABLE  = 1'b1;
   localparam logic        WRITEDISABLE = 1'b0;
   localparam logic        RSTENABLE_N  = 1'b0;
   localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;
   localparam logic [7:0]  EXE_AND_OP   = 8'b0010_0100;
   localparam logic [7:0]  EXE_OR_OP    = 8'b0010_0101;
   localparam logic [7:0]  EXE_XOR_OP   = 8'b0010_0110;
   localparam logic [7:0]  EXE_NOR_OP   = 8'b0010_0111;
   localparam logic [7:0]  EXE_SLL_OP   = 8'b0111_1100;
   localparam logic [7:0]  EXE_SRL_OP   = 8'b0000_0010;
   localparam logic [7:0]  EXE_SRA_OP   = 8'b0000_0011;
   localparam logic [7:0]  EXE_SRAV_OP  = 8'b0000_0111;
   localparam logic [7:0]  EXE_MOVZ_OP  = 8'b0000_1010;
   localparam logic [7:0]  EXE_MOVN_OP  = 8'b0000_1011;
   localparam logic [7:0]  EXE_MFHI_OP  = 8'b0001_0000;
   localparam logic [7:0]  EXE_MTHI_OP  = 8'b0001_0001;
   localparam logic [7:0]  EXE_MFLO_OP  = 8'b0001_0010;
   localparam logic [7:0]  EXE_MTLO_OP  = 8'b0001_0011;
   localparam logic [2:0]  EXE_RES_NOP   = 3'b000;
   localparam logic [2:0]  EXE_RES_LOGIC = 3'b001;
   localparam logic [2:0]  EXE_RES_SHIFT = 3'b010;
   localparam logic [2:0]  EXE_RES_MOVE  = 3'b011;
endpackage

// File: rtl/ex_stage_alu.sv
// ex_alu: combinational logic/shift/move result selection for the execute stage
//   i_aluop, i_alusel : operation and result class from the ID/EX latch
//   i_reg1, i_reg2    : operands (reg1[4:0] is the shift amount)
//   i_hi, i_lo        : current HI/LO for MFHI/MFLO
//   o_result          : value written back; 0 for NOP or any unlisted pair
module ex_alu
   import ex_stage_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ALUOP_W  = 8,
   parameter int ALUSEL_W = 3
) (
   input  logic [ALUOP_W-1:0]  i_aluop,
   input  logic [ALUSEL_W-1:0] i_alusel,
   input  logic [DATA_W-1:0]   i_reg1,
   input  logic [DATA_W-1:0]   i_reg2,
   input  logic [DATA_W-1:0]   i_hi,
   input  logic [DATA_W-1:0]   i_lo,
   output logic [DATA_W-1:0]   o_result
);
   logic [4:0] w_sa;
   assign w_sa = i_reg1[4:0];
   always_comb begin
      o_result = '0;
      case (i_alusel)
         EXE_RES_LOGIC:
            case (i_aluop)
               EXE_OR_OP:  o_result = i_reg1 | i_reg2;
               EXE_AND_OP: o_result = i_reg1 & i_reg2;
               EXE_XOR_OP: o_result = i_reg1 ^ i_reg2;
               EXE_NOR_OP: o_result = ~(i_reg1 | i_reg2);
               default:    o_result = '0;
            endcase
         EXE_RES_SHIFT:
            case (i_aluop)
               EXE_SLL_OP:              o_result = i_reg2 << w_sa;
               EXE_SRL_OP:              o_result = i_reg2 >> w_sa;
               EXE_SRA_OP, EXE_SRAV_OP: o_result = $unsigned($signed(i_reg2) >>> w_sa);
               default:                 o_result = '0;
            endcase
         EXE_RES_MOVE:
            case (i_aluop)
               EXE_MFHI_OP:              o_result = i_hi;
               EXE_MFLO_OP:              o_result = i_lo;
               EXE_MOVN_OP, EXE_MOVZ_OP: o_result = i_reg1;
               default:                  o_result = '0;
            endcase
         default: o_result = '0;
      endcase
   end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with ID/EX latch, ALU, HI/LO and EX/MEM latch
//   clk, rst (async, active-low), stall_i freezes both latches and HI/LO
//   aluop_i/alusel_i/reg1_i/reg2_i/wd_i/wreg_i : decoded bundle from ID
//   ex_*  : combinational result of the bundle held in ID/EX (forwarded to ID)
//   mem_* : EX/MEM latch contents (to MEM, forwarded to ID)
//   hi_o, lo_o : current HI/LO
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int REGADDR_W = 5,
   parameter int ALUOP_W   = 8,
   parameter int ALUSEL_W  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_i,
   input  logic [ALUOP_W-1:0]   aluop_i,
   input  logic [ALUSEL_W-1:0]  alusel_i,
   input  logic [DATA_W-1:0]    reg1_i,
   input  logic [DATA_W-1:0]    reg2_i,
   input  logic [REGADDR_W-1:0] wd_i,
   input  logic                 wreg_i,
   output logic                 ex_wreg_o,
   output logic [REGADDR_W-1:0] ex_wd_o,
   output logic [DATA_W-1:0]    ex_wdata_o,
   output logic                 mem_wreg_o,
   output logic [REGADDR_W-1:0] mem_wd_o,
   output logic [DATA_W-1:0]    mem_wdata_o,
   output logic [DATA_W-1:0]    hi_o,
   output logic [DATA_W-1:0]    lo_o
);
   logic [ALUOP_W-1:0]   r_aluop;
   logic [ALUSEL_W-1:0]  r_alusel;
   logic [DATA_W-1:0]    r_reg1, r_reg2, r_hi, r_lo, r_mem_wdata;
   logic [REGADDR_W-1:0] r_wd, r_mem_wd;
   logic                 r_wreg, r_mem_wreg;
   logic [DATA_W-1:0]    w_result;

   ex_alu #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W)) u_alu (
      .i_aluop  (r_aluop),
      .i_alusel (r_alusel),
      .i_reg1   (r_reg1),
      .i_reg2   (r_reg2),
      .i_hi     (r_hi),
      .i_lo     (r_lo),
      .o_result (w_result)
   );

   // HI/LO commit on the same edge that moves the instruction into EX/MEM,
   // so a stalled MTHI/MTLO is held in ID/EX and written exactly once.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RSTENABLE_N) begin
         r_aluop     <= EXE_NOP_OP;
         r_alusel    <= EXE_RES_NOP;
         r_reg1      <= '0;
         r_reg2      <= '0;
         r_wd        <= '0;
         r_wreg      <= WRITEDISABLE;
         r_mem_wreg  <= WRITEDISABLE;
         r_mem_wd    <= '0;
         r_mem_wdata <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
      end else if (!stall_i) begin
         r_aluop     <= aluop_i;
         r_alusel    <= alusel_i;
         r_reg1      <= reg1_i;
         r_reg2      <= reg2_i;
         r_wd        <= wd_i;
         r_wreg      <= wreg_i;
         r_mem_wreg  <= r_wreg;
         r_mem_wd    <= r_wd;
         r_mem_wdata <= w_result;
         if (r_aluop == EXE_MTHI_OP) r_hi <= r_reg1;
         if (r_aluop == EXE_MTLO_OP) r_lo <= r_reg1;
      end
   end

   assign ex_wreg_o   = r_wreg;
   assign ex_wd_o     = r_wd;
   assign ex_wdata_o  = w_result;
   assign mem_wreg_o  = r_mem_wreg;
   assign mem_wd_o    = r_mem_wd;
   assign mem_wdata_o = r_mem_wdata;
   assign hi_o        = r_hi;
   assign lo_o        = r_lo;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage (ex_* one cycle after issue, mem_* two)
module tb_ex_stage;
   import ex_stage_pkg::*;

   typedef struct {
      logic        wreg;
      logic [4:0]  wd;
      logic [31:0] wdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall_i = 1'b0;
   logic [7:0]  aluop_i = '0;
   logic [2:0]  alusel_i = '0;
   logic [31:0] reg1_i = '0, reg2_i = '0;
   logic [4:0]  wd_i = '0;
   logic        wreg_i = 1'b0;
   logic        ex_wreg_o, mem_wreg_o;
   logic [4:0]  ex_wd_o, mem_wd_o;
   logic [31:0] ex_wdata_o, mem_wdata_o, hi_o, lo_o;

   int   n_checks = 0;
   int   n_fail = 0;
   exp_t ex_q[$];
   exp_t mem_q[$];
   exp_t last_mem;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .rst(rst), .stall_i(stall_i),
      .aluop_i(aluop_i), .alusel_i(alusel_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
      .wd_i(wd_i), .wreg_i(wreg_i),
      .ex_wreg_o(ex_wreg_o), .ex_wd_o(ex_wd_o), .ex_wdata_o(ex_wdata_o),
      .mem_wreg_o(mem_wreg_o), .mem_wd_o(mem_wd_o), .mem_wdata_o(mem_wdata_o),
      .hi_o(hi_o), .lo_o(lo_o)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic check_ex(input string tag, input exp_t e);
      check({tag, ".ex_wreg"}, 32'(ex_wreg_o), 32'(e.wreg));
      check({tag, ".ex_wd"}, 32'(ex_wd_o), 32'(e.wd));
      check({tag, ".ex_wdata"}, ex_wdata_o, e.wdata);
   endtask

   task automatic check_mem(input string tag, input exp_t e);
      check({tag, ".mem_wreg"}, 32'(mem_wreg_o), 32'(e.wreg));
      check({tag, ".mem_wd"}, 32'(mem_wd_o), 32'(e.wd));
      check({tag, ".mem_wdata"}, mem_wdata_o, e.wdata);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".ex_wreg"}, 32'(ex_wreg_o), 32'd0);
      check({tag, ".ex_wd"}, 32'(ex_wd_o), 32'd0);
      check({tag, ".ex_wdata"}, ex_wdata_o, ZEROWORD);
      check({tag, ".mem_wreg"}, 32'(mem_wreg_o), 32'd0);
      check({tag, ".mem_wd"}, 32'(mem_wd_o), 32'd0);
      check({tag, ".mem_wdata"}, mem_wdata_o, ZEROWORD);
      check({tag, ".hi"}, hi_o, ZEROWORD);
      check({tag, ".lo"}, lo_o, ZEROWORD);
   endtask

   // Called #1 after a non-stalled edge: mem shows the older op, ex the newest.
   task automatic check_stage(input string tag);
      exp_t e;
      if (mem_q.size() > 0) begin
         last_mem = mem_q.pop_front();
         check_mem(tag, last_mem);
      end
      if (ex_q.size() > 0) begin
         e = ex_q.pop_front();
         check_ex(tag, e);
         mem_q.push_back(e);
      end
   endtask

   task automatic issue(input string tag, input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] exp_wdata);
      aluop_i = op; alusel_i = sel; reg1_i = r1; reg2_i = r2; wd_i = wd; wreg_i = wreg;
      ex_q.push_back('{wreg, wd, exp_wdata});
      @(posedge clk); #1;
      check_stage(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 check_all_zero("reset");
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      issue("mthi_pre", EXE_MTHI_OP, EXE_RES_NOP, 32'hDEAD0000, 0, 0, WRITEDISABLE, 0);
      issue("or_inflight", EXE_OR_OP, EXE_RES_LOGIC, 32'h0000F0F0, 32'h00000F0F, 3, WRITEENABLE, 32'h0000FFFF);
      check("hi_before_reset", hi_o, 32'hDEAD0000);
      #2 rst = 1'b0;
      #1 check_all_zero("async_reset");
      ex_q.delete(); mem_q.delete();
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      check("hi_after_release", hi_o, ZEROWORD);
      check("lo_after_release", lo_o, ZEROWORD);

      issue("or",   EXE_OR_OP,  EXE_RES_LOGIC, 32'h0000F0F0, 32'h00000F0F, 3, 1, 32'h0000FFFF);
      issue("and",  EXE_AND_OP, EXE_RES_LOGIC, 32'hFF00FF00, 32'h0FF00FF0, 1, 1, 32'h0F000F00);
      issue("xor",  EXE_XOR_OP, EXE_RES_LOGIC, 32'hFF00FF00, 32'h0FF00FF0, 2, 1, 32'hF0F0F0F0);
      issue("nor",  EXE_NOR_OP, EXE_RES_LOGIC, 32'hFF00FF00, 32'h0FF00FF0, 4, 1, 32'h000F000F);
      issue("sra4", EXE_SRA_OP, EXE_RES_SHIFT, 4, 32'h80000000, 8, 1, 32'hF8000000);
      issue("srl4", EXE_SRL_OP, EXE_RES_SHIFT, 4, 32'h80000000, 9, 1, 32'h08000000);
      issue("sll4", EXE_SLL_OP, EXE_RES_SHIFT, 4, 32'h80000000, 10, 1, 32'h00000000);
      issue("srav4", EXE_SRAV_OP, EXE_RES_SHIFT, 4, 32'h80000000, 11, 1, 32'hF8000000);
      issue("sra0", EXE_SRA_OP, EXE_RES_SHIFT, 0, 32'h12345678, 12, 1, 32'h12345678);
      issue("srl0", EXE_SRL_OP, EXE_RES_SHIFT, 0, 32'h12345678, 13, 1, 32'h12345678);
      issue("sll0", EXE_SLL_OP, EXE_RES_SHIFT, 0, 32'h12345678, 14, 1, 32'h12345678);
      issue("sll_amt_low5", EXE_SLL_OP, EXE_RES_SHIFT, 32'h00000024, 32'h00000001, 15, 1, 32'h00000010);
      issue("mthi", EXE_MTHI_OP, EXE_RES_NOP, 32'h12345678, 0, 0, 0, 0);
      issue("mfhi", EXE_MFHI_OP, EXE_RES_MOVE, 0, 0, 5, 1, 32'h12345678);
      check("hi_after_mthi", hi_o, 32'h12345678);
      issue("movn", EXE_MOVN_OP, EXE_RES_MOVE, 32'hCAFEBABE, 0, 16, 1, 32'hCAFEBABE);
      issue("movz", EXE_MOVZ_OP, EXE_RES_MOVE, 32'h0BADF00D, 0, 17, 0, 32'h0BADF00D);
      issue("default", 8'hFF, EXE_RES_NOP, 32'hFFFFFFFF, 32'hFFFFFFFF, 7, 1, 0);
      issue("unlisted", EXE_SLL_OP, EXE_RES_LOGIC, 32'hFFFFFFFF, 32'hFFFFFFFF, 18, 1, 0);
      issue("r0_dest", EXE_OR_OP, EXE_RES_LOGIC, 32'h1, 32'h2, 0, 1, 32'h3);

      issue("mtlo", EXE_MTLO_OP, EXE_RES_NOP, 32'hA5A5A5A5, 0, 6, 0, 0);
      stall_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         aluop_i = EXE_OR_OP; alusel_i = EXE_RES_LOGIC; reg1_i = 32'h1111 * (i + 1);
         reg2_i = 32'h0F0F; wd_i = 5'(20 + i); wreg_i = 1'b1;
         @(posedge clk); #1;
         check_ex("stall_ex", mem_q[0]);
         check_mem("stall_mem", last_mem);
         check("stall_lo", lo_o, ZEROWORD);
      end
      stall_i = 1'b0;
      issue("unstall_or", EXE_OR_OP, EXE_RES_LOGIC, 32'h00FF0000, 32'h000000FF, 21, 1, 32'h00FF00FF);
      check("lo_after_unstall", lo_o, 32'hA5A5A5A5);
      issue("mflo", EXE_MFLO_OP, EXE_RES_MOVE, 0, 0, 22, 1, 32'hA5A5A5A5);
      check("lo_written_once", lo_o, 32'hA5A5A5A5);
      issue("nop1", EXE_NOP_OP, EXE_RES_NOP, 0, 0, 0, 0, 0);
      issue("nop2", EXE_NOP_OP, EXE_RES_NOP, 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
